// File: rtl/tmr_pkg.sv
// Shared types and the width-generic next-value function for the TMR shift register.
package tmr_pkg;

  typedef enum logic [2:0] {
    SISO_R = 3'd0,
    SISO_L = 3'd1,
    PISO   = 3'd2,
    PIPO   = 3'd3,
    ROT_R  = 3'd4,
    ROT_L  = 3'd5,
    HOLD_A = 3'd6,
    HOLD_B = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DEGRADED = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam logic [2:0] MODE_HOLD = 3'd6;
  localparam int unsigned PCNT_W = 4;

  // Parameterised wrapper so the same pure function serves any register width.
  virtual class shifter #(parameter int W = 8);
    static function logic [W-1:0] shift_next(input logic [W-1:0] q,
                                             input mode_e       mode,
                                             input logic        load,
                                             input logic        serial_in,
                                             input logic [W-1:0] parallel_in);
      logic [W-1:0] n;
      case (mode)
        SISO_R:  n = {serial_in, q[W-1:1]};
        SISO_L:  n = {q[W-2:0], serial_in};
        PISO:    n = load ? parallel_in : {1'b0, q[W-1:1]};
        PIPO:    n = load ? parallel_in : q;
        ROT_R:   n = {q[0], q[W-1:1]};
        ROT_L:   n = {q[W-2:0], q[W-1]};
        default: n = q;
      endcase
      return n;
    endfunction
  endclass

endpackage

// File: rtl/tmr_replica.sv
// One storage replica of the TMR register; it only ever loads the voted next value.
module tmr_replica #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Replica storage, frozen when the write enable is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/tmr_shift_reg_scrub.sv
// Triple-redundant universal shift register with voted-next-state scrubbing and fault FSM.
// Optional per-replica error counters are built when TMR_ERR_CNT_EN is defined.
module tmr_shift_reg_scrub
  import tmr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PERSIST_LIM = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               load,
  input  logic               serial_in,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   parallel_in,
  input  logic               clear_fault,
  output logic [WIDTH-1:0]   parallel_out,
  output logic               serial_out,
  output logic               corr_pulse,
  output logic [2:0]         replica_failed,
  output logic               fatal,
  output logic [3*CNT_W-1:0] err_cnt
);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERSIST_LIM - 1);

  state_e            state_q;
  logic [2:0]        failed_q;
  logic [PCNT_W-1:0] pcnt_q [3];
  logic [WIDTH-1:0]  rep_q_s [3];
  logic [WIDTH-1:0]  rep_d;
  logic              rep_we_s;
  logic [WIDTH-1:0]  maj_s;
  logic [WIDTH-1:0]  voted_s;
  logic [2:0]        healthy_s;
  logic [2:0]        mismatch_s;
  logic [2:0]        fail_set_s;
  logic              all_diff_s;
  logic              multi_fail_s;
  logic              shift_en_s;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    tmr_replica #(.WIDTH(WIDTH)) u_rep (
      .clk_i (clk),
      .rst_ni(rst),
      .we_i  (rep_we_s),
      .d_i   (rep_d),
      .q_o   (rep_q_s[gi])
    );
  end

  assign healthy_s  = ~failed_q;
  assign maj_s      = (rep_q_s[0] & rep_q_s[1]) | (rep_q_s[0] & rep_q_s[2]) | (rep_q_s[1] & rep_q_s[2]);
  assign all_diff_s = (rep_q_s[0] != rep_q_s[1]) && (rep_q_s[1] != rep_q_s[2]) &&
                      (rep_q_s[0] != rep_q_s[2]);
  assign shift_en_s = enable && (mode[2:1] != MODE_HOLD[2:1]);

  // Voter: majority with three healthy replicas, lowest healthy replica once degraded.
  always_comb begin
    voted_s = maj_s;
    if (state_q == DEGRADED) begin
      if (healthy_s[0]) begin
        voted_s = rep_q_s[0];
      end else if (healthy_s[1]) begin
        voted_s = rep_q_s[1];
      end else begin
        voted_s = rep_q_s[2];
      end
    end else begin
      voted_s = maj_s;
    end
  end

  // Per-replica disagreement and the edge on which persistence crosses the limit.
  always_comb begin
    mismatch_s = 3'b000;
    fail_set_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      mismatch_s[i] = (state_q != FAULT) && healthy_s[i] && (rep_q_s[i] != voted_s);
      fail_set_s[i] = mismatch_s[i] && (pcnt_q[i] == PCNT_LAST);
    end
  end

  assign multi_fail_s = (fail_set_s[0] & fail_set_s[1]) | (fail_set_s[0] & fail_set_s[2]) |
                        (fail_set_s[1] & fail_set_s[2]);

  // Every replica, failed or not, is rewritten from the vote so a single upset heals at once.
  always_comb begin
    rep_we_s = 1'b1;
    rep_d    = voted_s;
    if (state_q == FAULT) begin
      rep_we_s = clear_fault;
      rep_d    = parallel_in;
    end else if (shift_en_s) begin
      rep_d = tmr_pkg::shifter#(WIDTH)::shift_next(voted_s, mode_e'(mode), load, serial_in,
                                                  parallel_in);
    end else begin
      rep_d = voted_s;
    end
  end

  // Health state machine; an unknown encoding falls into FAULT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (all_diff_s || multi_fail_s) begin
            state_q <= FAULT;
          end else if (|fail_set_s) begin
            state_q <= DEGRADED;
          end else begin
            state_q <= RUN;
          end
        end
        DEGRADED: begin
          if ((|mismatch_s) || (|fail_set_s)) begin
            state_q <= FAULT;
          end else begin
            state_q <= DEGRADED;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state_q <= RUN;
          end else begin
            state_q <= FAULT;
          end
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  // Persistence counters and sticky failed mask; counters stop once their replica fails.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      failed_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        pcnt_q[i] <= '0;
      end
    end else if (state_q == FAULT) begin
      if (clear_fault) begin
        failed_q <= 3'b000;
        for (int i = 0; i < 3; i++) begin
          pcnt_q[i] <= '0;
        end
      end else begin
        failed_q <= failed_q;
      end
    end else begin
      failed_q <= failed_q | fail_set_s;
      for (int i = 0; i < 3; i++) begin
        if (failed_q[i]) begin
          pcnt_q[i] <= pcnt_q[i];
        end else if (mismatch_s[i]) begin
          pcnt_q[i] <= pcnt_q[i] + PCNT_W'(1);
        end else begin
          pcnt_q[i] <= '0;
        end
      end
    end
  end

`ifdef TMR_ERR_CNT_EN
  logic [CNT_W-1:0] err_q [3];

  // Lifetime mismatch counters, saturating; clear_fault leaves them intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        err_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mismatch_s[i] && (err_q[i] != {CNT_W{1'b1}})) begin
          err_q[i] <= err_q[i] + CNT_W'(1);
        end else begin
          err_q[i] <= err_q[i];
        end
      end
    end
  end

  assign err_cnt = {err_q[2], err_q[1], err_q[0]};
`else
  assign err_cnt = '0;
`endif

  // Serial tap follows the shift direction of the selected mode.
  always_comb begin
    serial_out = 1'b0;
    if (state_q == FAULT) begin
      serial_out = 1'b0;
    end else begin
      case (mode_e'(mode))
        SISO_R, PISO, ROT_R: serial_out = voted_s[0];
        default:             serial_out = voted_s[WIDTH-1];
      endcase
    end
  end

  assign fatal          = (state_q == FAULT);
  assign replica_failed = failed_q;
  assign parallel_out   = (state_q == FAULT) ? '0 : voted_s;
  assign corr_pulse     = |mismatch_s;

endmodule

// File: tb/tb_tmr_shift_reg_scrub.sv
// Bench for tmr_shift_reg_scrub: directed fault scenarios plus randomized traffic vs a reference model.
module tb_tmr_shift_reg_scrub;

  localparam int W        = 8;
  localparam int LIM      = 4;
  localparam int ST_RUN   = 0;
  localparam int ST_DEG   = 1;
  localparam int ST_FAULT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic        serial_in;
  logic [2:0]  mode;
  logic [7:0]  parallel_in;
  logic        clear_fault;
  logic [7:0]  parallel_out;
  logic        serial_out;
  logic        corr_pulse;
  logic [2:0]  replica_failed;
  logic        fatal;
  logic [23:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_rep [3];
  logic [2:0] m_failed;
  int         m_pers [3];
  int         m_err [3];
  int         m_st;
  logic [7:0] sn [3];
  logic [7:0] vote;
  logic [2:0] mm;
  logic [2:0] fon;
  logic [7:0] fv0, fv1, fv2;
  bit         upset_prev;
  int         r;

  tmr_shift_reg_scrub #(.WIDTH(8), .PERSIST_LIM(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .load          (load),
    .serial_in     (serial_in),
    .mode          (mode),
    .parallel_in   (parallel_in),
    .clear_fault   (clear_fault),
    .parallel_out  (parallel_out),
    .serial_out    (serial_out),
    .corr_pulse    (corr_pulse),
    .replica_failed(replica_failed),
    .fatal         (fatal),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] v, input int m, input logic ld,
                                          input logic si, input logic [7:0] p);
    case (m)
      0:       return (v >> 1) | (8'(si) << 7);
      1:       return (v << 1) | 8'(si);
      2:       return ld ? p : (v >> 1);
      3:       return ld ? p : v;
      4:       return (v >> 1) | (v << 7);
      5:       return (v << 1) | (v >> 7);
      default: return v;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_rep[i]  = 8'h00;
      m_pers[i] = 0;
      m_err[i]  = 0;
    end
    m_failed = 3'b000;
    m_st     = ST_RUN;
  endtask

  task automatic set_force(input int idx, input logic [7:0] val);
    fon[idx] = 1'b1;
    case (idx)
      0:       begin fv0 = val; force dut.g_rep[0].u_rep.q_o = fv0; end
      1:       begin fv1 = val; force dut.g_rep[1].u_rep.q_o = fv1; end
      default: begin fv2 = val; force dut.g_rep[2].u_rep.q_o = fv2; end
    endcase
  endtask

  task automatic release_all();
    release dut.g_rep[0].u_rep.q_o;
    release dut.g_rep[1].u_rep.q_o;
    release dut.g_rep[2].u_rep.q_o;
    fon = 3'b000;
  endtask

  // Observed replica values, the vote, and which healthy replicas disagree with it.
  task automatic model_eval();
    int c;
    sn[0] = fon[0] ? fv0 : m_rep[0];
    sn[1] = fon[1] ? fv1 : m_rep[1];
    sn[2] = fon[2] ? fv2 : m_rep[2];
    if (m_st == ST_DEG) begin
      vote = sn[2];
      if (!m_failed[1]) vote = sn[1];
      if (!m_failed[0]) vote = sn[0];
    end else begin
      for (int b = 0; b < W; b++) begin
        c = 0;
        for (int i = 0; i < 3; i++) if (sn[i][b]) c++;
        vote[b] = (c >= 2);
      end
    end
    for (int i = 0; i < 3; i++) mm[i] = (m_st != ST_FAULT) && !m_failed[i] && (sn[i] != vote);
  endtask

  task automatic check_outputs();
    logic [7:0]  ep;
    logic        es;
    logic [31:0] ee;
    ep = (m_st == ST_FAULT) ? 8'h00 : vote;
    if (m_st == ST_FAULT) es = 1'b0;
    else if (mode == 3'd0 || mode == 3'd2 || mode == 3'd4) es = vote[0];
    else es = vote[W-1];
    chk("parallel_out", parallel_out, ep);
    chk("serial_out", serial_out, es);
    chk("corr_pulse", corr_pulse, |mm);
    chk("fatal", fatal, m_st == ST_FAULT);
    chk("replica_failed", replica_failed, m_failed);
`ifdef TMR_ERR_CNT_EN
    ee = m_err[2] * 65536 + m_err[1] * 256 + m_err[0];
`else
    ee = 0;
`endif
    chk("err_cnt", err_cnt, ee);
  endtask

  // What the coming rising edge does to the architectural state.
  task automatic model_advance();
    logic [7:0] nx;
    logic [2:0] newly;
    logic [7:0] hv[$];
    bit         differ;
    if (m_st == ST_FAULT) begin
      if (clear_fault) begin
        for (int i = 0; i < 3; i++) begin
          m_rep[i]  = parallel_in;
          m_pers[i] = 0;
        end
        m_failed = 3'b000;
        m_st     = ST_RUN;
      end
    end else begin
      nx    = enable ? ref_next(vote, int'(mode), load, serial_in, parallel_in) : vote;
      newly = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (!m_failed[i]) begin
          if (mm[i]) begin
            m_pers[i]++;
            if (m_pers[i] == LIM) newly[i] = 1'b1;
          end else begin
            m_pers[i] = 0;
          end
          hv.push_back(sn[i]);
        end
        if (mm[i] && m_err[i] < 255) m_err[i]++;
      end
      if (m_st == ST_RUN) begin
        if ((sn[0] != sn[1] && sn[1] != sn[2] && sn[0] != sn[2]) || $countones(newly) >= 2)
          m_st = ST_FAULT;
        else if ($countones(newly) == 1)
          m_st = ST_DEG;
      end else begin
        differ = (hv.size() >= 2) && (hv[0] != hv[1]);
        if (differ || $countones(newly) >= 1) m_st = ST_FAULT;
      end
      m_failed = m_failed | newly;
      for (int i = 0; i < 3; i++) m_rep[i] = nx;
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] md, input logic ld, input logic si,
                       input logic [7:0] pin, input logic clr);
    @(negedge clk);
    enable      = en;
    mode        = md;
    load        = ld;
    serial_in   = si;
    parallel_in = pin;
    clear_fault = clr;
  endtask

  task automatic settle();
    #1;
    model_eval();
    check_outputs();
    model_advance();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; load = 1'b0; serial_in = 1'b0; mode = 3'd0;
    parallel_in = 8'h00; clear_fault = 1'b0; fon = 3'b000;
    fv0 = 8'h00; fv1 = 8'h00; fv2 = 8'h00; upset_prev = 1'b0; r = 0;
    model_reset();
    #3;
    model_eval();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Parallel load of A5
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'hA5, 1'b0); settle();
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); settle();
    chk("load_a5", parallel_out, 8'hA5);
    chk("load_a5_corr", corr_pulse, 1'b0);

    // Single-cycle upset on replica 1 during a right shift
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0); settle();
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0); set_force(1, 8'h01); settle();
    chk("upset_corr", corr_pulse, 1'b1);
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0); release_all(); settle();
    chk("upset_seq0", parallel_out, 8'h80);
    chk("upset_repaired", corr_pulse, 1'b0);
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0); settle();
    chk("upset_seq1", parallel_out, 8'hC0);
`ifdef TMR_ERR_CNT_EN
    chk("upset_errcnt1", err_cnt[15:8], 8'd1);
`endif

    // Replica 2 bit 3 stuck at 1 until it is declared failed
    drive(1'b1, 3'd3, 1'b1, 1'b0, 8'h00, 1'b0); settle();
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); set_force(2, 8'h08); settle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); settle();
      chk("stuck_corr", corr_pulse, 1'b1);
    end
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); settle();
    chk("stuck_failed", replica_failed, 3'b100);
    chk("stuck_corr_off", corr_pulse, 1'b0);
    chk("stuck_pout", parallel_out, 8'h00);
    chk("stuck_not_fatal", fatal, 1'b0);
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); release_all(); settle();

    // Healthy pair disagrees while degraded, then recover with clear_fault
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); set_force(0, 8'h01); settle();
    chk("deg_diff_corr", corr_pulse, 1'b1);
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0); settle();
    chk("deg_fatal", fatal, 1'b1);
    chk("deg_pout_zero", parallel_out, 8'h00);
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0); release_all(); settle();
    chk("fault_hold", fatal, 1'b1);
    chk("fault_serial", serial_out, 1'b0);
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h3C, 1'b1); settle();
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); settle();
    chk("clr_pout", parallel_out, 8'h3C);
    chk("clr_failed", replica_failed, 3'b000);
    chk("clr_fatal", fatal, 1'b0);

    // Three pairwise-different replicas
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0);
    set_force(0, 8'h01); set_force(1, 8'h02); set_force(2, 8'h04); settle();
    chk("three_way_corr", corr_pulse, 1'b1);
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); release_all(); settle();
    chk("three_way_fatal", fatal, 1'b1);

    // Asynchronous reset while in FAULT with shifting requested
    drive(1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    enable = 1'b0;
    #1;
    chk("rst_fatal", fatal, 1'b0);
    chk("rst_pout", parallel_out, 8'h00);
    chk("rst_serial", serial_out, 1'b0);
    chk("rst_corr", corr_pulse, 1'b0);
    chk("rst_failed", replica_failed, 3'b000);
    chk("rst_errcnt", err_cnt, 24'h000000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 3'd6, 1'b0, 1'b0, 8'h00, 1'b0); settle();

    // Random traffic, the second half with occasional single-cycle upsets
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 15) == 0));
      release_all();
      if (n >= 200 && !upset_prev && m_st == ST_RUN && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 2);
        set_force(r, m_rep[r] ^ 8'($urandom_range(1, 255)));
        upset_prev = 1'b1;
      end else begin
        upset_prev = 1'b0;
      end
      settle();
    end
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_shift_reg_scrub.md
Name: tmr_shift_reg_scrub

Overview:
- Parametrised triple-modular-redundant universal shift register.
- Width-generic majority voter; voted-next-state correction that keeps all replicas in lockstep.
- Persistent-fault detection per replica; degraded two-replica operation; sticky fatal state.
- Sits in the same datapath slot as the current TMR register and is the drop-in successor for radiation-hardened shift/load storage.

Parameters:
- WIDTH, 8, data width in bits, must be >= 2.
- PERSIST_LIM, 4, consecutive mismatch cycles before a replica is declared failed, range 2..15.
- CNT_W, 8, width of each per-replica error counter (used only with TMR_ERR_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  advance register by current mode.
- load  in  1  parallel load qualifier (PISO/PIPO modes).
- serial_in  in  1  serial data in.
- mode  in  3  operation, encoding in package.
- parallel_in  in  WIDTH  parallel data.
- clear_fault  in  1  leave FAULT, reload replicas, clear failed mask.
- parallel_out  out  WIDTH  voted register value.
- serial_out  out  1  voted serial output.
- corr_pulse  out  1  one-cycle pulse: a correction occurred this cycle.
- replica_failed  out  3  sticky per-replica failed mask.
- fatal  out  1  high while in FAULT.
- err_cnt  out  3*CNT_W  per-replica error counters, replica 0 in LSBs.

Behaviour:
- Reset: async on rst low. All replicas 0, persistence counters 0, replica_failed 0, err_cnt 0, state RUN. Outputs: parallel_out 0, serial_out 0, corr_pulse 0, fatal 0.
- Modes: 0 SISO_R = {serial_in, q[W-1:1]}; 1 SISO_L = {q[W-2:0], serial_in}; 2 PISO = load ? parallel_in : {0, q[W-1:1]}; 3 PIPO = load ? parallel_in : q; 4 ROT_R; 5 ROT_L; 6, 7 HOLD.
- serial_out = voted[0] for modes 0, 2, 4; voted[W-1] otherwise.
- Voter, RUN state: bitwise majority of all three replicas.
- Voter, DEGRADED state: value of the lowest-index healthy replica.
- Next state: every healthy replica loads next(voted) if enable is high, else voted. A faulty replica is therefore repaired in the same edge with no lost shift, and no stall occurs.
- Failed replicas are still written but are excluded from voting and comparison.
- mismatch_i = healthy_i && (q_i != voted). corr_pulse = |mismatch, combinational.
- Persistence counter per replica:
  - Increments on mismatch, clears on match.
  - On reaching PERSIST_LIM, the replica's replica_failed bit is set on that edge; the counter then holds.
- FSM states RUN, DEGRADED, FAULT:
  - RUN -> DEGRADED when exactly one replica becomes failed.
  - RUN -> FAULT when all three replicas are pairwise unequal, or two or more replicas fail on the same edge.
  - DEGRADED -> FAULT when the two healthy replicas differ, or a second replica fails.
  - FAULT -> RUN on clear_fault: all replicas load parallel_in, replica_failed clears, persistence counters clear. err_cnt is kept.
- In FAULT: replicas frozen; enable ignored; parallel_out = 0; serial_out = 0; corr_pulse = 0; fatal = 1.
- clear_fault in RUN or DEGRADED: ignored.
- Reset mid-operation: immediate return to reset values, including sticky bits.

Optional Feature:
- Macro: TMR_ERR_CNT_EN.
- Defined: err_cnt[i] increments, saturating at all-ones, on every cycle where mismatch_i is high. Cleared only by reset.
- Undefined: no counter flops; err_cnt tied to 0.

Decomposition:
- Package tmr_pkg holds:
  - mode_e enum (3-bit, values above).
  - state_e enum {RUN, DEGRADED, FAULT}.
  - MODE_HOLD constant.
  - Pure function shift_next(q, mode, load, serial_in, parallel_in), generic on width via parameterised class or let-style macro.
- Sub-module tmr_replica: one register with a load-voted-next port, instantiated 3x via generate.
- Voter, persistence counters and FSM stay in the top module.

Test Plan:
- WIDTH=8, mode 3, load=1, parallel_in=8'hA5, one cycle -> parallel_out=8'hA5, corr_pulse=0, state RUN.
- Force replica 1 bit 0 flipped for one cycle while mode 0 shifts serial_in=1 from 8'h00 -> corr_pulse pulses once; parallel_out sequence 8'h80, 8'hC0 unaffected; replica 1 equal to the others the next cycle; err_cnt[1]=1 (with TMR_ERR_CNT_EN).
- Stick replica 2 bit 3 at 1 with data 8'h00, PERSIST_LIM=4 -> replica_failed=3'b100 after 4 cycles; state DEGRADED; parallel_out stays 8'h00; corr_pulse stops.
- In DEGRADED, force replica 0 to 8'h01 while replica 1 = 8'h00 -> fatal=1 next cycle; parallel_out=0; enable ignored; then clear_fault with parallel_in=8'h3C -> RUN, replica_failed=0, parallel_out=8'h3C.
- Force the three replicas to 8'h01, 8'h02, 8'h04 simultaneously -> FAULT on the next edge.
- Assert rst low mid-shift in FAULT -> all outputs 0 asynchronously; state RUN after release; err_cnt 0.
